// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone port arbiter: FSM states,
// one-hot grant codes and the saturating diagnostic counter helper.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_arb_rr2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the master that was not served last.
module wb_arb_rr2
  import wb_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    case (req_i)
      2'b01:   gnt_o = GNT_M0;
      2'b10:   gnt_o = GNT_M1;
      2'b11:   gnt_o = last_i ? GNT_M0 : GNT_M1;
      default: gnt_o = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter with round-robin grant,
// one transfer per grant, bus timeout with error termination and a timeout tally.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [1:0]        m_cyc_i,
  input  logic [1:0]        m_stb_i,
  input  logic [1:0]        m_we_i,
  input  logic [2*DW/8-1:0] m_sel_i,
  input  logic [2*AW-1:0]   m_adr_i,
  input  logic [2*DW-1:0]   m_dat_i,
  output logic [1:0]        m_ack_o,
  output logic [1:0]        m_err_o,
  output logic [DW-1:0]     m_dat_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              tmo_o,
  output logic [7:0]        tmo_cnt_o
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;

  logic [1:0] req;
  logic [1:0] pick;
  logic       g;

  assign req = m_cyc_i & m_stb_i;
  assign g   = grant_q[1];

  wb_arb_rr2 u_rr2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = 2'b00;
    m_err_o   = 2'b00;
    tmo_o     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick != GNT_NONE) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        s_cyc_o = m_cyc_i[g] & m_stb_i[g];
        s_stb_o = m_cyc_i[g] & m_stb_i[g];
        s_we_o  = m_we_i[g];
        s_sel_o = g ? m_sel_i[SW +: SW] : m_sel_i[0 +: SW];
        s_adr_o = g ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
        s_dat_o = g ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
        // Master abandoning its cycle takes priority; ack then beats timeout.
        if (!m_cyc_i[g]) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          last_d  = g;
        end else if (s_ack_i) begin
          m_ack_o = grant_q;
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          last_d  = g;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_ABORT: begin
        m_err_o   = grant_q;
        tmo_o     = 1'b1;
        tmo_cnt_d = sat_inc8(tmo_cnt_q);
        last_d    = g;
        grant_d   = GNT_NONE;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      tmo_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign tmo_cnt_o = tmo_cnt_q;

endmodule
